// File: rtl/video_capture.sv
// Frame grabber: decimates the vclk pixel stream 2x2 and writes one armed frame
// as RGB444 words through a small FIFO onto a valid/ready write port.
module video_capture #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   input  logic [3:0]        video_r,
   input  logic [3:0]        video_g,
   input  logic [3:0]        video_b,
   input  logic              video_de,
   input  logic              video_newframe,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data
);

   localparam int unsigned COL_W  = $clog2(H_ACTIVE);
   localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned HALF_W = H_ACTIVE / 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        r_state;
   logic [COL_W-1:0]  r_col;
   logic [LINE_W-1:0] r_line;
   logic              r_de_d;
   logic              r_ovf;
   logic              r_stg_valid;
   logic [ADDR_W-1:0] r_stg_addr;
   logic [15:0]       r_stg_data;
   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [15:0]       r_fifo_data [FIFO_DEPTH];
   logic [PTR_W:0]    r_wptr;
   logic [PTR_W:0]    r_rptr;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push_ok;
   logic              w_drop;
   logic              w_de_fall;
   logic              w_keep;
   logic              w_drain_done;
   logic [ADDR_W-1:0] w_addr;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_pop     = !w_empty && wr_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok = r_stg_valid && (!w_full || w_pop);
   assign w_drop    = r_stg_valid && w_full && !w_pop;
   assign w_de_fall = r_de_d && !video_de;
   assign w_keep    = (r_state == S_CAPT) && video_de && !abort &&
                      !r_col[0] && !r_line[0];
   assign w_addr    = ADDR_W'((32'(r_line >> 1) * HALF_W) + 32'(r_col >> 1));
   assign w_drain_done = (r_state == S_DRAIN) && w_empty && !r_stg_valid;

   assign busy     = (r_state != S_IDLE);
   assign done     = w_drain_done && !abort;
   assign overflow = r_ovf;
   assign wr_valid = !w_empty;
   assign wr_addr  = r_fifo_addr[r_rptr[PTR_W-1:0]];
   assign wr_data  = r_fifo_data[r_rptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_col       <= '0;
         r_line      <= '0;
         r_de_d      <= 1'b0;
         r_ovf       <= 1'b0;
         r_stg_valid <= 1'b0;
         r_stg_addr  <= '0;
         r_stg_data  <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_addr[i] <= '0;
            r_fifo_data[i] <= '0;
         end
      end else begin
         r_de_d <= video_de;
         if (abort) begin
            r_state     <= S_IDLE;
            r_stg_valid <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
         end else begin
            r_stg_valid <= w_keep;
            if (w_keep) begin
               r_stg_addr <= w_addr;
               r_stg_data <= {4'h0, video_r, video_g, video_b};
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok) begin
               r_fifo_addr[r_wptr[PTR_W-1:0]] <= r_stg_addr;
               r_fifo_data[r_wptr[PTR_W-1:0]] <= r_stg_data;
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_drop) begin
               r_ovf <= 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  if (arm) begin
                     r_state <= S_WAIT;
                     r_ovf   <= 1'b0;
                     r_col   <= '0;
                     r_line  <= '0;
                  end
               end
               S_WAIT: begin
                  if (video_newframe) begin
                     r_state <= S_CAPT;
                     r_col   <= '0;
                     r_line  <= '0;
                  end
               end
               S_CAPT: begin
                  if (video_newframe) begin
                     r_state <= S_DRAIN;
                  end else if (video_de) begin
                     // Saturating on an odd column drops the excess of an over-long line.
                     if (r_col != COL_W'(H_ACTIVE - 1)) begin
                        r_col <= r_col + 1'b1;
                     end
                  end else if (w_de_fall) begin
                     r_col  <= '0;
                     r_line <= r_line + 1'b1;
                     if (r_line == LINE_W'(V_ACTIVE - 1)) begin
                        r_state <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  if (w_drain_done) begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture on a reduced 16x8 raster: stimulus queues
// expected writes, a negedge monitor pops and compares on each accepted word.
module tb_video_capture;

   localparam int H      = 16;
   localparam int V      = 8;
   localparam int AW     = 5;
   localparam int HW     = H / 2;
   localparam int NWORDS = (H / 2) * (V / 2);

   logic          clk = 1'b0;
   logic          reset_n, arm, abort;
   logic          busy, done, overflow;
   logic [3:0]    video_r, video_g, video_b;
   logic          video_de, video_newframe;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;

   video_capture #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .ADDR_W     (AW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .arm            (arm),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow),
      .video_r        (video_r),
      .video_g        (video_g),
      .video_b        (video_b),
      .video_de       (video_de),
      .video_newframe (video_newframe),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } exp_t;

   exp_t        sb_q[$];
   bit          sb_exact = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          last_addr = -1;
   int          wr_at_abort = 0;
   logic [15:0] mem [NWORDS];

   int rdy_mode  = 0;   // 0 always ready, 1 alternate, 2 never
   int stall_cnt = 0;

   int fr_expect     = 0;
   int fr_arm_line   = -1;
   int fr_abort_line = -1;
   int fr_long_line  = -1;
   int fr_long_len   = H;
   int fr_stall_line = -1;
   int fr_lat_chk    = 0;

   function automatic logic [15:0] pix(input int c, input int ln);
      logic [3:0] cr, lr, br;
      int s;
      s  = c + ln;
      cr = c[3:0];
      lr = ln[3:0];
      br = s[3:0];
      return {4'h0, cr, lr, br};
   endfunction

   task automatic check(input string nm, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sink readiness, applied after the stimulus so stall requests take effect deterministically.
   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (stall_cnt > 0) begin
            wr_ready = 1'b0;
            stall_cnt--;
         end else if (rdy_mode == 1) wr_ready = !wr_ready;
         else if (rdy_mode == 2)     wr_ready = 1'b0;
         else                        wr_ready = 1'b1;
      end
   end

   // Monitor: in exact mode each accepted word must match the queue head; in loose
   // mode (frames with drops) data must agree with its own address and addresses rise.
   initial begin
      exp_t        e;
      int          ad, ex, ey;
      logic [15:0] want;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (done) done_cnt++;
            if (wr_valid && wr_ready) begin
               wr_cnt++;
               ad = int'(wr_addr);
               mem[ad] = wr_data;
               n_chk++;
               if (sb_exact) begin
                  if (sb_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", ad, wr_data);
                  end else begin
                     e = sb_q.pop_front();
                     if (wr_addr !== e.addr || wr_data !== e.data) begin
                        n_fail++;
                        $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 ad, wr_data, e.addr, e.data);
                     end
                  end
               end else begin
                  ey   = ad / HW;
                  ex   = ad % HW;
                  want = pix(2 * ex, 2 * ey);
                  if (wr_data !== want || ad <= last_addr) begin
                     n_fail++;
                     $display("FAIL survivor: got addr=%0d data=%h, expected data=%h and addr>%0d",
                              ad, wr_data, want, last_addr);
                  end
               end
               last_addr = ad;
            end
         end
      end
   end

   task automatic cfg_default();
      fr_expect     = 0;
      fr_arm_line   = -1;
      fr_abort_line = -1;
      fr_long_line  = -1;
      fr_long_len   = H;
      fr_stall_line = -1;
      fr_lat_chk    = 0;
      sb_exact      = 1'b1;
      rdy_mode      = 0;
   endtask

   task automatic clear_stats();
      wr_cnt    = 0;
      done_cnt  = 0;
      last_addr = -1;
      sb_q.delete();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic send_frame(input int nlines);
      int          exp_on;
      int          len;
      logic [15:0] p;
      exp_t        e;
      exp_on = fr_expect;
      video_newframe = 1'b1;
      tick();
      video_newframe = 1'b0;
      tick();
      tick();
      for (int ln = 0; ln < nlines; ln++) begin
         len = (ln == fr_long_line) ? fr_long_len : H;
         for (int c = 0; c < len; c++) begin
            p        = pix(c, ln);
            video_de = 1'b1;
            video_r  = p[11:8];
            video_g  = p[7:4];
            video_b  = p[3:0];
            if (ln == fr_arm_line && c == 0) arm = 1'b1;
            if (ln == fr_abort_line && c == 0) begin
               abort  = 1'b1;
               exp_on = 0;
            end
            if (ln == fr_stall_line && c == 4) stall_cnt = 20;
            if (exp_on != 0 && c < H && (c % 2) == 0 && (ln % 2) == 0 && ln < V) begin
               e.addr = AW'((ln / 2) * HW + c / 2);
               e.data = p;
               sb_q.push_back(e);
            end
            tick();
            arm   = 1'b0;
            abort = 1'b0;
            if (fr_lat_chk != 0 && ln == 0 && c == 0) check("latency_n1_valid", wr_valid, 0);
            if (fr_lat_chk != 0 && ln == 0 && c == 1) check("latency_n2_valid", wr_valid, 1);
            if (ln == fr_abort_line && c == 0) begin
               check("abort_busy", busy, 0);
               wr_at_abort = wr_cnt;
            end
         end
         video_de = 1'b0;
         repeat (4) tick();
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check(nm, busy, 0);
      repeat (3) tick();
   endtask

   task automatic full_frame_checks(input string nm, input int words, input int ovf);
      check({nm, "_writes"}, wr_cnt, words);
      check({nm, "_done"}, done_cnt, 1);
      check({nm, "_overflow"}, overflow, ovf);
      check({nm, "_queue_left"}, sb_q.size(), 0);
   endtask

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      reset_n = 1'b0; arm = 1'b0; abort = 1'b0;
      video_de = 1'b0; video_newframe = 1'b0;
      video_r = '0; video_g = '0; video_b = '0;
      cfg_default();
      repeat (3) tick();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overflow", overflow, 0);
      check("reset_wr_valid", wr_valid, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      reset_n = 1'b1;
      tick();

      // Test 1: reset while capturing with three words queued and the sink stalled.
      rdy_mode = 2;
      tick();
      pulse_arm();
      video_newframe = 1'b1; tick(); video_newframe = 1'b0; tick();
      for (int c = 0; c < 6; c++) begin
         video_de = 1'b1;
         video_r  = 4'(c);
         tick();
      end
      video_de = 1'b0;
      repeat (3) tick();
      check("t1_busy_before", busy, 1);
      check("t1_valid_before", wr_valid, 1);
      reset_n = 1'b0;
      tick();
      check("t1_valid_after", wr_valid, 0);
      check("t1_busy_after", busy, 0);
      check("t1_overflow_after", overflow, 0);
      reset_n = 1'b1;
      cfg_default();
      repeat (2) tick();
      clear_stats();

      // Test 2: full ramp frame, sink always ready, with latency probe.
      fr_expect = 1; fr_lat_chk = 1;
      pulse_arm();
      check("t2_busy_armed", busy, 1);
      send_frame(V);
      wait_idle("t2_idle");
      full_frame_checks("t2", NWORDS, 0);
      check("t2_word_x1_y1", mem[HW + 1], 16'h0224);
      cfg_default(); clear_stats();

      // Test 3a: sink ready every other cycle.
      fr_expect = 1; rdy_mode = 1;
      pulse_arm();
      send_frame(V);
      wait_idle("t3a_idle");
      full_frame_checks("t3a", NWORDS, 0);
      cfg_default(); clear_stats();

      // Test 3b: 20-cycle stall mid-line causes drops; survivors keep their addresses.
      sb_exact = 1'b0; fr_stall_line = 2;
      pulse_arm();
      send_frame(V);
      wait_idle("t3b_idle");
      check("t3b_overflow", overflow, 1);
      check("t3b_some_dropped", (wr_cnt < NWORDS) ? 1 : 0, 1);
      check("t3b_done", done_cnt, 1);
      cfg_default(); clear_stats();

      // Test 4: arm mid-frame, then a second arm during capture, then an unarmed frame.
      fr_arm_line = 1;
      send_frame(3);
      check("t4_waiting", busy, 1);
      check("t4_no_early_writes", wr_cnt, 0);
      fr_expect = 1; fr_arm_line = 3;
      send_frame(V);
      wait_idle("t4_idle");
      full_frame_checks("t4", NWORDS, 0);
      fr_expect = 0; fr_arm_line = -1;
      send_frame(V);
      check("t4_unarmed_writes", wr_cnt, NWORDS);
      check("t4_unarmed_busy", busy, 0);
      cfg_default(); clear_stats();

      // Test 5: overflow, then abort at line 4; overflow must survive abort, clear on arm.
      sb_exact = 1'b0; fr_stall_line = 0; fr_abort_line = 4;
      pulse_arm();
      send_frame(V);
      check("t5_busy_end", busy, 0);
      check("t5_overflow_kept", overflow, 1);
      check("t5_no_writes_after_abort", wr_cnt, wr_at_abort);
      check("t5_no_done", done_cnt, 0);
      cfg_default(); clear_stats();
      fr_expect = 1;
      pulse_arm();
      check("t5_overflow_cleared", overflow, 0);
      send_frame(V);
      wait_idle("t5_idle");
      full_frame_checks("t5_rearm", NWORDS, 0);
      cfg_default(); clear_stats();

      // Test 6: over-long line 2 (22 pixels).
      fr_expect = 1; fr_long_line = 2; fr_long_len = H + 6;
      pulse_arm();
      send_frame(V);
      wait_idle("t6_idle");
      full_frame_checks("t6", NWORDS, 0);
      cfg_default(); clear_stats();

      // Test 7: short frame ended by an early newframe.
      fr_expect = 1;
      pulse_arm();
      send_frame(4);
      video_newframe = 1'b1; tick(); video_newframe = 1'b0;
      wait_idle("t7_idle");
      full_frame_checks("t7", (V / 4) * HW, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
